// File: rtl/instr_pair_packer.sv
// ============================================================================
// Module      : instr_pair_packer
// Description : Two-slot ordered packer that presents instruction words as
//               dual-issue pairs. Optional macro PACKER_AGE_FLUSH_EN holds a
//               lone word back until it is burst-last or has aged MaxWait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_pair_packer #(
  parameter int Width   = 32,
  parameter int MaxWait = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [Width-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [1:0]       out_valid_o,
  output logic [Width-1:0] out_data0_o,
  output logic [Width-1:0] out_data1_o,
  input  logic [1:0]       out_rdy_i
);

  localparam logic [3:0] c_max_wait = 4'(MaxWait);

  logic [1:0]       r_count;
  logic [Width-1:0] r_slot0;
  logic [Width-1:0] r_slot1;
  logic             r_last0;
  logic             r_last1;
  logic [3:0]       r_age;

  logic             w_aged;
  logic             w_present0;
  logic [1:0]       w_out_valid;
  logic [1:0]       w_nrd;
  logic [1:0]       w_remain;
  logic             w_accept;
  logic [1:0]       w_count_nxt;
  logic [Width-1:0] w_slot0_nxt;
  logic [Width-1:0] w_slot1_nxt;
  logic             w_last0_nxt;
  logic             w_last1_nxt;
  logic [3:0]       w_age_nxt;

  assign w_aged = (r_age >= c_max_wait);

`ifdef PACKER_AGE_FLUSH_EN
  assign w_present0 = r_last0 | w_aged;
`else
  logic w_unused_age;
  assign w_unused_age = w_aged | r_last0;
  assign w_present0   = 1'b1;
`endif

  always_comb begin
    w_out_valid = 2'b00;
    if (r_count == 2'd2) begin
      w_out_valid = 2'b11;
    end else if ((r_count == 2'd1) && w_present0) begin
      w_out_valid = 2'b01;
    end
  end

  assign in_ready_o  = (r_count < 2'd2);
  assign out_valid_o = w_out_valid;
  assign out_data0_o = r_slot0;
  assign out_data1_o = r_slot1;

  assign w_nrd    = {1'b0, w_out_valid[0] & out_rdy_i[0]}
                  + {1'b0, w_out_valid[1] & out_rdy_i[1]};
  assign w_remain = r_count - w_nrd;
  assign w_accept = in_valid_i & in_ready_o;

  // Survivors shift toward slot0 first; the new word lands right behind them.
  always_comb begin
    w_slot0_nxt = r_slot0;
    w_slot1_nxt = r_slot1;
    w_last0_nxt = r_last0;
    w_last1_nxt = r_last1;
    if (w_nrd == 2'd1) begin
      w_slot0_nxt = r_slot1;
      w_last0_nxt = r_last1;
    end
    if (w_accept) begin
      if (w_remain == 2'd0) begin
        w_slot0_nxt = in_data_i;
        w_last0_nxt = in_last_i;
      end else begin
        w_slot1_nxt = in_data_i;
        w_last1_nxt = in_last_i;
      end
    end
    w_count_nxt = w_remain + {1'b0, w_accept};
    w_age_nxt   = 4'd0;
    if ((r_count == 2'd1) && (w_count_nxt == 2'd1) && (w_nrd == 2'd0)) begin
      w_age_nxt = (r_age == 4'd15) ? r_age : r_age + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= 2'd0;
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_age   <= 4'd0;
    end else if (flush_i) begin
      // Slot data is left in place; out_valid_o alone qualifies it.
      r_count <= 2'd0;
      r_last0 <= 1'b0;
      r_last1 <= 1'b0;
      r_age   <= 4'd0;
    end else begin
      r_count <= w_count_nxt;
      r_slot0 <= w_slot0_nxt;
      r_slot1 <= w_slot1_nxt;
      r_last0 <= w_last0_nxt;
      r_last1 <= w_last1_nxt;
      r_age   <= w_age_nxt;
    end
  end

endmodule

`default_nettype wire
